// File: rtl/sram_addr_seq.sv
`default_nettype none
// ============================================================================
// Module   : sram_addr_seq
// Purpose  : Captures the shifter word as the SRAM address and runs single
//            read/write access cycles with programmable wait states.
// Option   : SRAM_ADDR_SEQ_AUTOINC_EN - address +1 after every access.
// Revision : 1.0 - initial release
// ============================================================================
module sram_addr_seq #(
    parameter int DWIDTH   = 21,
    parameter int WAIT_CYC = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic [DWIDTH-1:0] addr_in,
    input  logic              rd_req,
    input  logic              wr_req,
    output logic [DWIDTH-1:0] sram_addr,
    output logic              sram_ce_n,
    output logic              sram_oe_n,
    output logic              sram_we_n,
    output logic              data_oe,
    output logic              busy,
    output logic              done
);

    localparam logic [3:0] c_CNT_INIT = 4'(WAIT_CYC - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETUP  = 2'd1,
        S_ACTIVE = 2'd2,
        S_HOLD   = 2'd3
    } state_t;

    state_t            r_state;
    logic [3:0]        r_cnt;
    logic              r_wr;
    logic              r_en_q;
    logic              r_pend;
    logic [DWIDTH-1:0] r_pend_addr;
    logic              r_def_vld;
    logic              r_def_wr;
    logic [DWIDTH-1:0] r_addr;
    logic              r_ce_n;
    logic              r_oe_n;
    logic              r_we_n;
    logic              r_data_oe;
    logic              r_busy;
    logic              r_done;

    logic w_load_ev;
    logic w_req_any;
    logic w_req_wr;

    assign w_load_ev = ~r_en_q & en;
    // A request deferred by a same-edge load outranks fresh requests.
    assign w_req_any = r_def_vld | rd_req | wr_req;
    assign w_req_wr  = r_def_vld ? r_def_wr : (~rd_req & wr_req);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_cnt       <= 4'd0;
            r_wr        <= 1'b0;
            r_en_q      <= 1'b1;
            r_pend      <= 1'b0;
            r_pend_addr <= '0;
            r_def_vld   <= 1'b0;
            r_def_wr    <= 1'b0;
            r_addr      <= '0;
            r_ce_n      <= 1'b1;
            r_oe_n      <= 1'b1;
            r_we_n      <= 1'b1;
            r_data_oe   <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_en_q    <= en;
            // Pins follow the state register one cycle later.
            r_ce_n    <= (r_state == S_IDLE);
            r_oe_n    <= !((r_state == S_ACTIVE) && !r_wr);
            r_we_n    <= !((r_state == S_ACTIVE) && r_wr);
            r_data_oe <= (r_state != S_IDLE) && r_wr;
            r_done    <= (r_state == S_IDLE) && !r_ce_n;

            if ((r_state != S_IDLE) && w_load_ev) begin
                r_pend      <= 1'b1;
                r_pend_addr <= addr_in;
            end

            case (r_state)
                S_IDLE: begin
                    if (w_load_ev) begin
                        r_addr <= addr_in;
                        r_pend <= 1'b0;
                    end else if (r_pend) begin
                        r_addr <= r_pend_addr;
                        r_pend <= 1'b0;
                    end
                    if (w_req_any && (w_load_ev || r_pend)) begin
                        r_def_vld <= 1'b1;
                        r_def_wr  <= w_req_wr;
                    end else if (w_req_any) begin
                        r_def_vld <= 1'b0;
                        r_wr      <= w_req_wr;
                        r_state   <= S_SETUP;
                        r_busy    <= 1'b1;
                    end
                end
                S_SETUP: begin
                    r_cnt   <= c_CNT_INIT;
                    r_state <= S_ACTIVE;
                end
                S_ACTIVE: begin
                    if (r_cnt == 4'd0) begin
                        r_state <= S_HOLD;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                S_HOLD: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
`ifdef SRAM_ADDR_SEQ_AUTOINC_EN
                    // A load waiting to be applied wins over the increment.
                    if (!w_load_ev && !r_pend) begin
                        r_addr <= r_addr + 1'b1;
                    end
`endif
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign sram_addr = r_addr;
    assign sram_ce_n = r_ce_n;
    assign sram_oe_n = r_oe_n;
    assign sram_we_n = r_we_n;
    assign data_oe   = r_data_oe;
    assign busy      = r_busy;
    assign done      = r_done;

endmodule
`default_nettype wire

// File: tb/tb_sram_addr_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_sram_addr_seq
// Purpose  : Directed and randomized bench for sram_addr_seq with a
//            timeline-based reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sram_addr_seq;

    localparam int W  = 2;
    localparam int DW = 21;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          en = 1'b1;
    logic [DW-1:0] addr_in = '0;
    logic          rd_req = 1'b0;
    logic          wr_req = 1'b0;
    logic [DW-1:0] sram_addr;
    logic          sram_ce_n, sram_oe_n, sram_we_n, data_oe, busy, done;

    int vectors = 0;
    int miscompares = 0;

    // Reference model: an access is described by its start edge and kind;
    // every pin is derived from its offset against that edge.
    int            cyc = 0;
    bit            m_acc = 0;
    int            m_k = 0;
    bit            m_wr = 0;
    int            m_prev_done = -1;
    bit            m_enq = 1;
    bit            m_pend = 0;
    logic [DW-1:0] m_pv = '0;
    logic [DW-1:0] m_addr = '0;
    bit            m_def = 0;
    int            m_defk = 0;

    sram_addr_seq #(.DWIDTH(DW), .WAIT_CYC(W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .addr_in  (addr_in),
        .rd_req   (rd_req),
        .wr_req   (wr_req),
        .sram_addr(sram_addr),
        .sram_ce_n(sram_ce_n),
        .sram_oe_n(sram_oe_n),
        .sram_we_n(sram_we_n),
        .data_oe  (data_oe),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp);
        end
    endtask

    task automatic model_edge();
        bit ev, idle, hold, loaded;
        int kind;
        cyc++;
        if (!rst_n) begin
            m_acc = 0; m_prev_done = -1; m_addr = '0; m_pend = 0;
            m_enq = 1; m_def = 0;
            return;
        end
        ev   = !m_enq && en;
        idle = !m_acc || (cyc >= m_k + W + 3);
        hold = m_acc && (cyc == m_k + W + 2);
        if (idle) begin
            loaded = 0;
            if (ev) begin
                m_addr = addr_in; m_pend = 0; loaded = 1;
            end else if (m_pend) begin
                m_addr = m_pv; m_pend = 0; loaded = 1;
            end
            kind = m_def ? m_defk : (rd_req ? 1 : (wr_req ? 2 : 0));
            if (kind != 0) begin
                if (loaded) begin
                    m_def = 1; m_defk = kind;
                end else begin
                    m_def = 0;
                    m_prev_done = m_acc ? (m_k + W + 3) : -1;
                    m_acc = 1; m_k = cyc; m_wr = (kind == 2);
                end
            end
        end else begin
            if (ev) begin
                m_pend = 1; m_pv = addr_in;
            end
`ifdef SRAM_ADDR_SEQ_AUTOINC_EN
            if (hold && !m_pend) m_addr = m_addr + 1'b1;
`endif
        end
        m_enq = en;
    endtask

    task automatic check_all();
        bit in_ce, in_strb, e_busy, e_done;
        in_ce   = m_acc && (cyc >= m_k + 1) && (cyc <= m_k + W + 2);
        in_strb = m_acc && (cyc >= m_k + 2) && (cyc <= m_k + W + 1);
        e_busy  = m_acc && (cyc >= m_k) && (cyc <= m_k + W + 1);
        e_done  = (m_acc && (cyc == m_k + W + 3)) || (cyc == m_prev_done);
        chk("sram_addr", {11'b0, sram_addr}, {11'b0, m_addr});
        chk("ce_n", {31'b0, sram_ce_n}, {31'b0, !in_ce});
        chk("oe_n", {31'b0, sram_oe_n}, {31'b0, !(in_strb && !m_wr)});
        chk("we_n", {31'b0, sram_we_n}, {31'b0, !(in_strb && m_wr)});
        chk("data_oe", {31'b0, data_oe}, {31'b0, in_ce && m_wr});
        chk("busy", {31'b0, busy}, {31'b0, e_busy});
        chk("done", {31'b0, done}, {31'b0, e_done});
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic idle_steps(input int n);
        rd_req = 1'b0;
        wr_req = 1'b0;
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        logic [DW-1:0] base;

        // Reset held with a read request pending: nothing may start.
        rst_n = 1'b0; rd_req = 1'b1;
        step(); step();
        chk("rst_addr", {11'b0, sram_addr}, 32'h0);
        chk("rst_ce_n", {31'b0, sram_ce_n}, 32'h1);
        chk("rst_busy", {31'b0, busy}, 32'h0);
        chk("rst_done", {31'b0, done}, 32'h0);
        rst_n = 1'b1; rd_req = 1'b0;
        idle_steps(2);

        // Shift burst then word-complete edge.
        addr_in = 21'h1ABCDE; en = 1'b0;
        for (int i = 0; i < 21; i++) step();
        en = 1'b1;
        step();
        chk("load_addr", {11'b0, sram_addr}, 32'h1ABCDE);
        idle_steps(1);

        // Single read.
        rd_req = 1'b1; step();
        idle_steps(5);
        chk("rd_done", {31'b0, done}, 32'h1);
        idle_steps(1);

        // Simultaneous requests: read wins; then a plain write.
        rd_req = 1'b1; wr_req = 1'b1; step();
        idle_steps(6);
        wr_req = 1'b1; step();
        idle_steps(6);

`ifdef SRAM_ADDR_SEQ_AUTOINC_EN
        base = 21'h1ABCDE + 21'd3;
`else
        base = 21'h1ABCDE;
`endif
        // Load arriving during ACTIVE is parked until the access ends.
        rd_req = 1'b1; step();
        rd_req = 1'b0; en = 1'b0; step();
        en = 1'b1; addr_in = 21'h000123; step();
        chk("busy_load_hold", {11'b0, sram_addr}, {11'b0, base});
        step();
        chk("hold_edge_addr", {11'b0, sram_addr}, {11'b0, base});
        idle_steps(3);
        chk("pending_applied", {11'b0, sram_addr}, 32'h000123);

        // Address wrap at all-ones.
        en = 1'b0; addr_in = 21'h1FFFFF; step();
        en = 1'b1; step();
        chk("wrap_load", {11'b0, sram_addr}, 32'h1FFFFF);
        rd_req = 1'b1; step();
        idle_steps(6);
`ifdef SRAM_ADDR_SEQ_AUTOINC_EN
        chk("wrap_after", {11'b0, sram_addr}, 32'h000000);
`else
        chk("wrap_after", {11'b0, sram_addr}, 32'h1FFFFF);
`endif

        // Randomized traffic with occasional reset.
        for (int i = 0; i < 3000; i++) begin
            rst_n   = ($urandom_range(0, 299) != 0);
            if ($urandom_range(0, 7) == 0) en = ~en;
            addr_in = DW'($urandom);
            rd_req  = ($urandom_range(0, 7) == 0);
            wr_req  = ($urandom_range(0, 5) == 0);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
